// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl : IF/ID/EXE/MEM/WB control FSM for the multicycle MIPS core
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
   parameter int INSTR_CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   run,
   input  logic [5:0]             opcode,
   input  logic [5:0]             funct,
   input  logic                   zero,
   output logic                   pc_we,
   output logic [1:0]             pc_src,
   output logic                   i_or_d,
   output logic                   mem_rd,
   output logic                   mem_wr,
   output logic                   ir_we,
   output logic                   reg_we,
   output logic                   reg_dst,
   output logic                   mem_to_reg,
   output logic                   ext_sel,
   output logic [1:0]             alu_src_a,
   output logic [2:0]             alu_src_b,
   output logic [2:0]             alu_op,
   output logic [2:0]             state,
   output logic                   halted,
   output logic                   illegal,
   output logic [INSTR_CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EXE  = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   state_t                 state_q, state_d;
   logic [INSTR_CNT_W-1:0] instr_count_q, instr_count_d;

   logic       is_r, r_ok, r_shift, legal;
   logic [2:0] r_alu_op;

   always_comb begin
      r_ok     = 1'b1;
      r_shift  = 1'b0;
      r_alu_op = 3'b000;
      case (funct)
         6'b100000: r_alu_op = 3'b000;
         6'b100010: r_alu_op = 3'b001;
         6'b101010: r_alu_op = 3'b010;
         6'b000010: begin r_alu_op = 3'b011; r_shift = 1'b1; end
         6'b000000: begin r_alu_op = 3'b100; r_shift = 1'b1; end
         6'b100101: r_alu_op = 3'b101;
         6'b100100: r_alu_op = 3'b110;
         6'b100110: r_alu_op = 3'b111;
         default:   r_ok = 1'b0;
      endcase
      is_r = (opcode == OP_RTYPE);
      case (opcode)
         OP_RTYPE:                                   legal = r_ok;
         OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ,
         OP_J, OP_HALT:                              legal = 1'b1;
         default:                                    legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      instr_count_d = instr_count_q;
      pc_we         = 1'b0;
      pc_src        = 2'b00;
      i_or_d        = 1'b0;
      mem_rd        = 1'b0;
      mem_wr        = 1'b0;
      ir_we         = 1'b0;
      reg_we        = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      ext_sel       = 1'b0;
      alu_src_a     = 2'b00;
      alu_src_b     = 3'b000;
      alu_op        = 3'b000;
      halted        = 1'b0;
      illegal       = 1'b0;
      // Everything stays at its inactive default while reset is held.
      if (!rst) begin
         case (state_q)
            S_IF: begin
               if (run) begin
                  mem_rd        = 1'b1;
                  ir_we         = 1'b1;
                  alu_src_b     = 3'b001;
                  pc_we         = 1'b1;
                  instr_count_d = instr_count_q + 1'b1;
                  state_d       = S_ID;
               end
            end
            S_ID: begin
               // ALU precomputes the branch target into ALUOut.
               alu_src_b = 3'b011;
               ext_sel   = 1'b1;
               if (!legal) begin
                  illegal = 1'b1;
                  state_d = S_IF;
               end else if (opcode == OP_J) begin
                  pc_src  = 2'b10;
                  pc_we   = 1'b1;
                  state_d = S_IF;
               end else if (opcode == OP_HALT) begin
                  state_d = S_HALT;
               end else begin
                  state_d = S_EXE;
               end
            end
            S_EXE: begin
               alu_src_a = 2'b01;
               state_d   = S_IF;
               if (is_r) begin
                  alu_op  = r_alu_op;
                  state_d = S_WB;
                  if (r_shift) begin
                     alu_src_a = 2'b10;
                     alu_src_b = 3'b100;
                  end
               end else if (opcode == OP_ADDI || opcode == OP_LW || opcode == OP_SW) begin
                  alu_src_b = 3'b010;
                  ext_sel   = 1'b1;
                  state_d   = (opcode == OP_ADDI) ? S_WB : S_MEM;
               end else if (opcode == OP_ORI) begin
                  alu_src_b = 3'b010;
                  alu_op    = 3'b101;
                  state_d   = S_WB;
               end else if (opcode == OP_BEQ) begin
                  alu_op = 3'b001;
                  pc_src = 2'b01;
                  pc_we  = zero;
               end
            end
            S_MEM: begin
               i_or_d  = 1'b1;
               state_d = S_IF;
               if (opcode == OP_LW) begin
                  mem_rd  = 1'b1;
                  state_d = S_WB;
               end else if (opcode == OP_SW) begin
                  mem_wr = 1'b1;
               end
            end
            S_WB: begin
               reg_we     = 1'b1;
               reg_dst    = is_r;
               mem_to_reg = (opcode == OP_LW);
               state_d    = S_IF;
            end
            S_HALT: begin
               halted = 1'b1;
            end
            default: state_d = S_IF;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IF;
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         instr_count_q <= instr_count_d;
      end
   end

   assign state       = state_q;
   assign instr_count = instr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl : randomized check of multicycle_ctrl against a per-instruction cycle-script model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

   localparam int CW = 4;   // narrow counter so wrap-around is reached

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          run = 1'b0;
   logic [5:0]    opcode = 6'd0;
   logic [5:0]    funct = 6'd0;
   logic          zero = 1'b0;
   logic          pc_we, i_or_d, mem_rd, mem_wr, ir_we, reg_we, reg_dst, mem_to_reg, ext_sel;
   logic [1:0]    pc_src, alu_src_a;
   logic [2:0]    alu_src_b, alu_op, state;
   logic          halted, illegal;
   logic [CW-1:0] instr_count;

   multicycle_ctrl #(.INSTR_CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct), .zero(zero),
      .pc_we(pc_we), .pc_src(pc_src), .i_or_d(i_or_d), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .ir_we(ir_we), .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .ext_sel(ext_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .state(state), .halted(halted), .illegal(illegal), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       i_or_d, mem_rd, mem_wr, ir_we, reg_we, reg_dst, mem_to_reg, ext_sel;
      logic [1:0] a;
      logic [2:0] b;
      logic [2:0] op;
      logic       halted, illegal;
   } rec_t;

   rec_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   function automatic rec_t observed();
      return {state, pc_we, pc_src, i_or_d, mem_rd, mem_wr, ir_we, reg_we, reg_dst,
              mem_to_reg, ext_sel, alu_src_a, alu_src_b, alu_op, halted, illegal};
   endfunction

   // {valid, alu_op} for an R-type funct code
   function automatic logic [3:0] r_info(input logic [5:0] fn);
      case (fn)
         6'b100000: return 4'b1000;
         6'b100010: return 4'b1001;
         6'b101010: return 4'b1010;
         6'b000010: return 4'b1011;
         6'b000000: return 4'b1100;
         6'b100101: return 4'b1101;
         6'b100100: return 4'b1110;
         6'b100110: return 4'b1111;
         default:   return 4'b0000;
      endcase
   endfunction

   function automatic bit legal_op(input logic [5:0] op);
      return op inside {6'b000000, 6'b001000, 6'b001101, 6'b100011,
                        6'b101011, 6'b000100, 6'b000010, 6'b111111};
   endfunction

   // Expected per-cycle control script of one instruction, from fetch to return.
   task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
      rec_t r;
      logic [3:0] ri;
      bit   is_r;
      ri   = r_info(fn);
      is_r = (op == 6'b000000);
      r = '0; r.mem_rd = 1; r.ir_we = 1; r.pc_we = 1; r.b = 3'b001;
      exp_q.push_back(r);
      r = '0; r.st = 3'd1; r.b = 3'b011; r.ext_sel = 1;
      if (!legal_op(op) || (is_r && !ri[3])) begin
         r.illegal = 1; exp_q.push_back(r); return;
      end
      if (op == 6'b000010) begin
         r.pc_src = 2'b10; r.pc_we = 1; exp_q.push_back(r); return;
      end
      exp_q.push_back(r);
      if (op == 6'b111111) return;
      r = '0; r.st = 3'd2; r.a = 2'b01;
      case (op)
         6'b000000: begin
            r.op = ri[2:0];
            if (fn == 6'b000010 || fn == 6'b000000) begin r.a = 2'b10; r.b = 3'b100; end
         end
         6'b001101: begin r.b = 3'b010; r.op = 3'b101; end
         6'b000100: begin r.op = 3'b001; r.pc_src = 2'b01; r.pc_we = z; end
         default:   begin r.b = 3'b010; r.ext_sel = 1; end
      endcase
      exp_q.push_back(r);
      if (op == 6'b000100) return;
      if (op == 6'b100011 || op == 6'b101011) begin
         r = '0; r.st = 3'd3; r.i_or_d = 1;
         if (op == 6'b100011) r.mem_rd = 1; else r.mem_wr = 1;
         exp_q.push_back(r);
         if (op == 6'b101011) return;
      end
      r = '0; r.st = 3'd4; r.reg_we = 1; r.reg_dst = is_r; r.mem_to_reg = (op == 6'b100011);
      exp_q.push_back(r);
   endtask

   task automatic push_idle(input int n);
      rec_t r;
      r = '0;
      repeat (n) exp_q.push_back(r);
   endtask

   task automatic push_halt(input int n);
      rec_t r;
      r = '0; r.st = 3'd5; r.halted = 1;
      repeat (n) exp_q.push_back(r);
   endtask

   // Plays up to n expected cycles; entered and left 1 time unit after a rising edge.
   task automatic run_recs(input int n, input string tag);
      rec_t r;
      for (int i = 0; i < n && exp_q.size() > 0; i++) begin
         r = exp_q.pop_front();
         if (r.st == 3'd0) run = r.ir_we;
         else              run = 1'($urandom_range(0, 1));
         #1;
         check($sformatf("%s op=%b fn=%b ctl", tag, opcode, funct), 32'(observed()), 32'(r));
         check($sformatf("%s count", tag), 32'(instr_count), 32'(cnt));
         @(posedge clk); #1;
         if (r.ir_we) cnt = (cnt + 1) % (1 << CW);
      end
   endtask

   task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input string tag);
      opcode = op; funct = fn; zero = z;
      push_instr(op, fn, z);
      run_recs(exp_q.size(), tag);
   endtask

   logic [5:0] functs [8] = '{6'b100000, 6'b100010, 6'b101010, 6'b000010,
                              6'b000000, 6'b100101, 6'b100100, 6'b100110};

   initial begin
      logic [5:0] op, fn;
      int k;
      // Reset held: every output inactive, even with run high.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         run = (i == 3);
         #1;
         check("reset ctl", 32'(observed()), 32'd0);
         check("reset count", 32'(instr_count), 32'd0);
      end
      rst = 0; run = 0;
      @(posedge clk); #1;
      push_idle(3);
      run_recs(3, "idle");

      do_instr(6'b000000, 6'b100000, 0, "add");
      do_instr(6'b100011, 6'b000000, 0, "lw");
      do_instr(6'b101011, 6'b000000, 0, "sw");
      do_instr(6'b000100, 6'b000000, 1, "beq_z1");
      do_instr(6'b000100, 6'b000000, 0, "beq_z0");
      do_instr(6'b000000, 6'b000010, 0, "srl");
      do_instr(6'b001101, 6'b000000, 0, "ori");
      do_instr(6'b000010, 6'b000000, 0, "j");
      do_instr(6'b010101, 6'b000000, 0, "bad_op");
      do_instr(6'b000000, 6'b111111, 0, "bad_fn");

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            opcode = 6'($urandom); funct = 6'($urandom);
            push_idle($urandom_range(1, 3));
            run_recs(exp_q.size(), "rnd_idle");
         end
         k  = $urandom_range(0, 9);
         fn = 6'($urandom);
         case (k)
            0, 1, 2: begin op = 6'b000000; fn = functs[$urandom_range(0, 7)]; end
            3: op = 6'b001000;
            4: op = 6'b001101;
            5: op = 6'b100011;
            6: op = 6'b101011;
            7: op = 6'b000100;
            8: op = 6'b000010;
            default: begin
               if ($urandom_range(0, 1) == 0) begin
                  do op = 6'($urandom); while (legal_op(op));
               end else begin
                  op = 6'b000000;
                  do fn = 6'($urandom); while (r_info(fn) != 4'b0000);
               end
            end
         endcase
         do_instr(op, fn, 1'($urandom_range(0, 1)), "rnd");
      end

      // Halt is terminal until reset.
      opcode = 6'b111111; funct = 6'd0;
      push_instr(6'b111111, 6'd0, 0);
      push_halt(8);
      run_recs(exp_q.size(), "halt");
      #2 rst = 1; #1;
      cnt = 0;
      check("rst_from_halt ctl", 32'(observed()), 32'd0);
      check("rst_from_halt count", 32'(instr_count), 32'd0);
      @(posedge clk); #1 rst = 0;

      // Reset asserted asynchronously in the EXE cycle of the next program.
      opcode = 6'b000000; funct = 6'b100000;
      push_instr(opcode, funct, 0);
      run_recs(2, "pre_exe");
      check("in_exe state", 32'(state), 32'd2);
      #2 rst = 1; #1;
      exp_q.delete();
      cnt = 0;
      check("rst_in_exe ctl", 32'(observed()), 32'd0);
      check("rst_in_exe count", 32'(instr_count), 32'd0);
      @(posedge clk); #1 rst = 0;
      do_instr(6'b100011, 6'd0, 0, "after_rst_lw");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS CPU. It sequences every instruction through IF/ID/EXE/MEM/WB and drives all datapath mux selects, write enables and the shared ALU opcode. Only one ALU exists, so the controller time-multiplexes it between PC+4, branch-target, execute and address computation. It sits between the instruction register (opcode/funct) and the datapath, and observes ALU zero for beq.

Parameters:
INSTR_CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
run  input  1  start/continue enable, sampled only in IF
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag
pc_we  output  1  PC write enable
pc_src  output  2  00 ALU result, 01 ALUOut reg, 10 jump target
i_or_d  output  1  memory address: 0 PC, 1 ALUOut
mem_rd  output  1  memory read
mem_wr  output  1  memory write
ir_we  output  1  instruction register write
reg_we  output  1  register file write
reg_dst  output  1  0 rt, 1 rd
mem_to_reg  output  1  0 ALUOut, 1 MDR
ext_sel  output  1  1 sign-extend imm16, 0 zero-extend
alu_src_a  output  2  00 PC, 01 reg A(rs), 10 reg B(rt)
alu_src_b  output  3  000 reg B, 001 const 4, 010 ext imm, 011 ext imm<<2, 100 zero-ext shamt
alu_op  output  3  000 add, 001 sub, 010 slt, 011 srl, 100 sll, 101 or, 110 and, 111 xor
state  output  3  IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5
halted  output  1  high while in HALT
illegal  output  1  one-cycle pulse on undecodable instruction in ID
instr_count  output  INSTR_CNT_W  count of instructions fetched

Behaviour:
- rst asserted (any time, incl. mid-instruction): state=IF, instr_count=0; all enables (pc_we, ir_we, mem_rd, mem_wr, reg_we) 0 while rst high; selects 0; illegal=0, halted=0.
- Outputs are combinational from state, opcode, funct, zero; only state and instr_count are registered.
- Supported: R-type (opcode 000000) funct add 100000, sub 100010, slt 101010, srl 000010, sll 000000, or 100101, and 100100, xor 100110; addi 001000, ori 001101, lw 100011, sw 101011, beq 000100, j 000010, halt 111111.
- IF: if run=0, stay in IF with all enables 0. If run=1: mem_rd=1, i_or_d=0, ir_we=1, alu_src_a=00, alu_src_b=001, alu_op=000, pc_src=00, pc_we=1; instr_count+1 (wraps to 0); next ID.
- ID: alu_src_a=00, alu_src_b=011, ext_sel=1, alu_op=000 (branch target into ALUOut). j: pc_src=10, pc_we=1, next IF. halt: next HALT. Unsupported opcode or R-type funct: illegal=1 for this cycle, no writes, next IF. Otherwise next EXE.
- EXE: R-type arith/logic: alu_src_a=01, alu_src_b=000, alu_op per funct map; sll/srl: alu_src_a=10, alu_src_b=100. addi/lw/sw: alu_src_a=01, alu_src_b=010, ext_sel=1, alu_op=000. ori: alu_src_b=010, ext_sel=0, alu_op=101. Next WB for R/addi/ori, MEM for lw/sw. beq: alu_src_a=01, alu_src_b=000, alu_op=001, pc_src=01, pc_we=zero; next IF.
- MEM: i_or_d=1; lw: mem_rd=1, next WB. sw: mem_wr=1, next IF.
- WB: reg_we=1; R-type reg_dst=1, mem_to_reg=0; addi/ori reg_dst=0, mem_to_reg=0; lw reg_dst=0, mem_to_reg=1; next IF.
- HALT: all enables 0, halted=1; exit only via rst.
- Cycle counts: j 2, beq 3, R/addi/ori/sw 4, lw 5.
- opcode/funct are stable from ID onward (IR written only in IF); no other inputs affect transitions.

Test Plan:
- rst high, run=0 for 5 cycles then rst low -> state=0, pc_we=ir_we=0, instr_count=0 until run=1.
- run=1, add (000000/100000) -> states 0,1,2,4,0; EXE alu_op=000, a=01, b=000; WB reg_we=1, reg_dst=1; instr_count=1.
- lw then sw -> lw visits 0,1,2,3,4 with mem_to_reg=1 in WB; sw visits 0,1,2,3 with mem_wr=1, i_or_d=1, no reg_we.
- beq with zero=1 then zero=0 -> EXE alu_op=001, pc_src=01, pc_we=1 then 0; both return to IF after 3 cycles.
- srl, ori, j, opcode 010101 -> srl EXE a=10, b=100, op=011; ori ext_sel=0, op=101; j pc_src=10 in ID; 010101 illegal=1 one cycle, no write.
- halt, then rst pulsed while in EXE of next program -> state 5, halted=1, enables 0 indefinitely; rst forces state=0 and instr_count=0 immediately.
